// File: rtl/rgbw_frame_sender.sv
// rtl/rgbw_frame_sender.sv - SPI mode-0 master sending the 8-byte RGBW lighting frame
module rgbw_frame_sender #(
    parameter int          CLK_DIV   = 2,
    parameter int          GAP       = 2,
    parameter logic [7:0]  SYNC_BYTE = 8'h55
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] lint_in,
    input  logic [7:0] color_idx_in,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    input  logic [7:0] white_in,
    input  logic [7:0] mode_in,
    output logic       busy,
    output logic       done,
    output logic [2:0] byte_idx,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n
);

    // Last value of the per-half-period divider and of the gap half-period counter.
    localparam logic [15:0] DIV_MAX  = 16'(CLK_DIV - 1);
    localparam logic [7:0]  GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_HOLD
    } state_t;

    state_t      r_state;

    // Frame snapshot taken on the accepting start edge.
    logic [7:0]  r_lint;
    logic [7:0]  r_color_idx;
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic [7:0]  r_blue;
    logic [7:0]  r_white;
    logic [7:0]  r_mode;

    logic [7:0]  r_shift;
    logic [2:0]  r_bit;
    logic [15:0] r_div;
    logic [7:0]  r_gap;

    logic        r_busy;
    logic        r_done;
    logic [2:0]  r_byte_idx;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_cs_n;

    logic [2:0]  w_next_idx;
    logic [7:0]  w_next_byte;
    logic        w_div_end;

    assign w_next_idx = r_byte_idx + 3'd1;
    assign w_div_end  = (r_div == DIV_MAX);

    // Pick the shadow byte that follows the one currently on the wire.
    always_comb begin
        w_next_byte = 8'h00;
        case (w_next_idx)
            3'd1:    w_next_byte = r_lint;
            3'd2:    w_next_byte = r_color_idx;
            3'd3:    w_next_byte = r_red;
            3'd4:    w_next_byte = r_green;
            3'd5:    w_next_byte = r_blue;
            3'd6:    w_next_byte = r_white;
            3'd7:    w_next_byte = r_mode;
            default: w_next_byte = SYNC_BYTE;
        endcase
    end

    // Frame sequencer: snapshot, bit timing, inter-byte gap, trailing hold and all outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_lint      <= 8'h00;
            r_color_idx <= 8'h00;
            r_red       <= 8'h00;
            r_green     <= 8'h00;
            r_blue      <= 8'h00;
            r_white     <= 8'h00;
            r_mode      <= 8'h00;
            r_shift     <= 8'h00;
            r_bit       <= 3'd0;
            r_div       <= 16'd0;
            r_gap       <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_byte_idx  <= 3'd0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lint      <= lint_in;
                        r_color_idx <= color_idx_in;
                        r_red       <= red_in;
                        r_green     <= green_in;
                        r_blue      <= blue_in;
                        r_white     <= white_in;
                        r_mode      <= mode_in;
                        r_shift     <= SYNC_BYTE;
                        r_mosi      <= SYNC_BYTE[7];
                        r_bit       <= 3'd0;
                        r_div       <= 16'd0;
                        r_byte_idx  <= 3'd0;
                        r_sclk      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cs_n      <= 1'b0;
                        r_state     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (!w_div_end) begin
                        r_div <= r_div + 16'd1;
                    end else begin
                        r_div <= 16'd0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit != 3'd7) begin
                                // Next bit of the same byte starts its low half.
                                r_bit   <= r_bit + 3'd1;
                                r_shift <= {r_shift[6:0], 1'b0};
                                r_mosi  <= r_shift[6];
                            end else begin
                                r_bit <= 3'd0;
                                if (r_byte_idx == 3'd7) begin
                                    r_state <= S_HOLD;
                                end else if (GAP == 0) begin
                                    r_byte_idx <= w_next_idx;
                                    r_shift    <= w_next_byte;
                                    r_mosi     <= w_next_byte[7];
                                end else begin
                                    r_gap   <= 8'd0;
                                    r_state <= S_GAP;
                                end
                            end
                        end
                    end
                end

                S_GAP: begin
                    // mosi keeps the last bit of the previous byte while sclk idles.
                    if (!w_div_end) begin
                        r_div <= r_div + 16'd1;
                    end else begin
                        r_div <= 16'd0;
                        if (r_gap == GAP_LAST) begin
                            r_byte_idx <= w_next_idx;
                            r_shift    <= w_next_byte;
                            r_mosi     <= w_next_byte[7];
                            r_state    <= S_SHIFT;
                        end else begin
                            r_gap <= r_gap + 8'd1;
                        end
                    end
                end

                S_HOLD: begin
                    // One half-period of cs hold after the last sclk fall.
                    if (!w_div_end) begin
                        r_div <= r_div + 16'd1;
                    end else begin
                        r_div      <= 16'd0;
                        r_cs_n     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_byte_idx <= 3'd0;
                        r_mosi     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign byte_idx = r_byte_idx;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;

endmodule
